sync_debounce_event: RTL and testbench



---
 rtl/sync_debounce_event.sv | 109 ++++++++++
 tb/tb_sync_debounce_event.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_event.sv
// Debounces a synchronized D-bit vector, emits per-bit edge pulses and queues change events.
// Optional DEBOUNCE_EVT_COUNT_EN adds a saturating 16-bit commit counter output evt_count.
module sync_debounce_event #(
  parameter int D      = 8,
  parameter int STABLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [D-1:0] data_in,
  output logic [D-1:0] data_stable,
  output logic [D-1:0] rise_pulse,
  output logic [D-1:0] fall_pulse,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [D-1:0] evt_data,
  output logic [D-1:0] evt_rise,
  output logic [D-1:0] evt_fall,
  output logic         ovf,
  input  logic         ovf_clr
`ifdef DEBOUNCE_EVT_COUNT_EN
  ,
  output logic [15:0]  evt_count
`endif
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

  logic [D-1:0]  cand;
  logic [CW-1:0] cnt;
  logic          same;
  logic          commit;
  logic          can_load;
  logic [D-1:0]  rise_next;
  logic [D-1:0]  fall_next;

  always_comb begin
    same      = (data_in == cand);
    commit    = same && (cnt == CNT_MAX) && (cand != data_stable);
    can_load  = !evt_valid || evt_ready;
    rise_next = cand & ~data_stable;
    fall_next = ~cand & data_stable;
  end

  // Any differing bit restarts the whole vector's stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (!same) begin
      cand <= data_in;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_stable <= '0;
      rise_pulse  <= '0;
      fall_pulse  <= '0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      if (commit) begin
        data_stable <= cand;
        rise_pulse  <= rise_next;
        fall_pulse  <= fall_next;
      end
    end
  end

  // A commit that finds the slot occupied and not being drained is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_data  <= '0;
      evt_rise  <= '0;
      evt_fall  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (commit && can_load) begin
        evt_valid <= 1'b1;
        evt_data  <= cand;
        evt_rise  <= rise_next;
        evt_fall  <= fall_next;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (commit && !can_load)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

`ifdef DEBOUNCE_EVT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      evt_count <= '0;
    else if (ovf_clr)
      evt_count <= commit ? 16'd1 : 16'd0;
    else if (commit && evt_count != 16'hFFFF)
      evt_count <= evt_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sync_debounce_event.sv
// Directed bench for sync_debounce_event (D=8, STABLE=4); checks evt_count when DEBOUNCE_EVT_COUNT_EN is defined.
module tb_sync_debounce_event;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic [7:0] data_stable, rise_pulse, fall_pulse;
  logic       evt_valid, evt_ready;
  logic [7:0] evt_data, evt_rise, evt_fall;
  logic       ovf, ovf_clr;
`ifdef DEBOUNCE_EVT_COUNT_EN
  logic [15:0] evt_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_debounce_event #(.D(8), .STABLE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_stable(data_stable),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_rise   (evt_rise),
    .evt_fall   (evt_fall),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef DEBOUNCE_EVT_COUNT_EN
    ,
    .evt_count  (evt_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] agg;

  initial begin
    rst = 1'b1; data_in = 8'h00; evt_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_stable", data_stable, 8'h00);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_evt_data", evt_data, 8'h00);
    agg = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      agg |= rise_pulse | fall_pulse | {7'b0, evt_valid} | data_stable;
    end
    check("settle_quiet", agg, 8'h00);

    // Clean change 00 -> 5A: commit on the 4th edge after the first sample
    data_in = 8'h5A;
    repeat (4) step();
    check("clean_not_yet", data_stable, 8'h00);
    step();
    check("clean_stable", data_stable, 8'h5A);
    check("clean_rise", rise_pulse, 8'h5A);
    check("clean_fall", fall_pulse, 8'h00);
    check("clean_valid", evt_valid, 1'b1);
    check("clean_evt_data", evt_data, 8'h5A);
    check("clean_evt_rise", evt_rise, 8'h5A);
    check("clean_evt_fall", evt_fall, 8'h00);
    step();
    check("clean_pulse_1cyc", rise_pulse, 8'h00);
    check("clean_hold_valid", evt_valid, 1'b1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("accept_clears", evt_valid, 1'b0);

    // Glitch to FF for 3 edges, back to 5A: nothing happens
    data_in = 8'hFF;
    repeat (3) step();
    data_in = 8'h5A;
    agg = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      agg |= rise_pulse | fall_pulse | {7'b0, evt_valid};
    end
    check("glitch_quiet", agg, 8'h00);
    check("glitch_stable", data_stable, 8'h5A);

    data_in = 8'h0F;
    repeat (4) step();
    step();
    check("0f_stable", data_stable, 8'h0F);
    check("0f_fall", fall_pulse, 8'h50);
    check("0f_rise", rise_pulse, 8'h05);
    check("0f_evt_fall", evt_fall, 8'h50);
    check("0f_evt_rise", evt_rise, 8'h05);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;

    // Backpressure: 01 queues, 03 is dropped
    data_in = 8'h01;
    repeat (5) step();
    check("bp1_valid", evt_valid, 1'b1);
    check("bp1_evt_data", evt_data, 8'h01);
    check("bp1_evt_fall", evt_fall, 8'h0E);
    check("bp1_ovf", ovf, 1'b0);
    data_in = 8'h03;
    repeat (5) step();
    check("bp2_stable", data_stable, 8'h03);
    check("bp2_rise", rise_pulse, 8'h02);
    check("bp2_evt_data_held", evt_data, 8'h01);
    check("bp2_ovf", ovf, 1'b1);
    data_in = 8'h07;
    repeat (4) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_vs_set_stable", data_stable, 8'h07);
    check("clr_vs_set_ovf", ovf, 1'b1);
    check("clr_vs_set_evt_data", evt_data, 8'h01);
`ifdef DEBOUNCE_EVT_COUNT_EN
    check("cnt_clr_commit", evt_count, 16'd1);
`endif
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_alone_ovf", ovf, 1'b0);
`ifdef DEBOUNCE_EVT_COUNT_EN
    check("cnt_clr_alone", evt_count, 16'd0);
`endif

    // Back-to-back: accept and commit on the same edge
    data_in = 8'h80;
    repeat (4) step();
    evt_ready = 1'b1;
    step();
    check("b2b_valid", evt_valid, 1'b1);
    check("b2b_evt_data", evt_data, 8'h80);
    check("b2b_evt_rise", evt_rise, 8'h80);
    check("b2b_evt_fall", evt_fall, 8'h07);
    step();
    evt_ready = 1'b0;
    check("b2b_drain", evt_valid, 1'b0);

    // Reset mid-debounce
    data_in = 8'hAA;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_stable", data_stable, 8'h00);
    check("mid_rst_valid", evt_valid, 1'b0);
    repeat (4) step();
    check("mid_rst_not_yet", data_stable, 8'h00);
    step();
    check("mid_rst_stable_aa", data_stable, 8'hAA);
    check("mid_rst_rise", rise_pulse, 8'hAA);
    check("mid_rst_valid_aa", evt_valid, 1'b1);
    check("mid_rst_evt_data", evt_data, 8'hAA);
`ifdef DEBOUNCE_EVT_COUNT_EN
    check("mid_rst_count", evt_count, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
